// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates the single memory cacheline port between I-cache and D-cache, one transaction at a time.
// Optional I-side starvation guard is enabled by defining MEM_ARB_STARVE_EN.
module cacheline_mem_arbiter #(
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              d_req;
  logic              grant_i;

  assign d_req = d_read | d_write;

`ifdef MEM_ARB_STARVE_EN
  localparam int unsigned CNT_W = 3;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // I overrides D priority once D has won STARVE_MAX grants while I was waiting
  assign grant_i = i_read & (~d_req | (starve_cnt_q == CNT_W'(STARVE_MAX)));
`else
  assign grant_i = i_read & ~d_req;
`endif

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_STARVE_EN
    starve_cnt_d = starve_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d    = I_BUSY;
          op_wr_d    = 1'b0;
          mem_addr_d = i_addr;
`ifdef MEM_ARB_STARVE_EN
          starve_cnt_d = '0;
`endif
        end else if (d_req) begin
          // a simultaneous read+write is resolved as a write
          state_d     = D_BUSY;
          op_wr_d     = d_write;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
`ifdef MEM_ARB_STARVE_EN
          if (i_read && (starve_cnt_q != '1)) starve_cnt_d = starve_cnt_q + CNT_W'(1);
`endif
        end
      end
      I_BUSY, D_BUSY: if (mem_resp) state_d = DONE;
      DONE:           state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_wr_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARB_STARVE_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_STARVE_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // Strobes decode from flopped state; responses are combinational on mem_resp
  assign mem_read  = (state_q == I_BUSY) | ((state_q == D_BUSY) & ~op_wr_q);
  assign mem_write = (state_q == D_BUSY) & op_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_resp    = rst & (state_q == I_BUSY) & mem_resp;
  assign d_resp    = rst & (state_q == D_BUSY) & mem_resp;
  assign i_rdata   = i_resp ? mem_rdata : '0;
  assign d_rdata   = d_resp ? mem_rdata : '0;

`ifndef SYNTHESIS
  d_rw_exclusive_a: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));
`endif

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Self-checking bench for cacheline_mem_arbiter: transaction-level model compared every cycle,
// plus directed literal checks of grant order, latency, reset abort and starvation behaviour.
module tb_cacheline_mem_arbiter;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, d_read, d_write, mem_resp;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, mem_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic              i_resp, d_resp, mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;

  cacheline_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int i_resp_cnt = 0;
  int d_resp_cnt = 0;
  int resp_log[$];
  logic [LINE_W-1:0] last_i_rdata = '0;
  logic [LINE_W-1:0] last_d_rdata = '0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: owner 0 = free, 1 = I transaction, 2 = D transaction, 3 = cool-down cycle
  int                m_owner = 0;
  int                m_starve = 0;
  bit                m_wr = 1'b0;
  bit                m_dq, m_gi;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [LINE_W-1:0] m_wdata = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_owner = 0; m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_starve = 0;
    end else begin
      case (m_owner)
        0: begin
          m_dq = d_read | d_write;
          m_gi = i_read && (!m_dq || (STARVE_EN && m_starve == int'(STARVE_MAX)));
          if (m_gi) begin
            m_owner = 1; m_wr = 1'b0; m_addr = i_addr; m_starve = 0;
          end else if (m_dq) begin
            m_owner = 2; m_wr = d_write; m_addr = d_addr; m_wdata = d_wdata;
            if (i_read && m_starve < 7) m_starve++;
          end
        end
        1, 2:    if (mem_resp) m_owner = 3;
        default: m_owner = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    logic e_rd, e_wr, e_ir, e_dr;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_rd = (m_owner == 1) || (m_owner == 2 && !m_wr);
      e_wr = (m_owner == 2) && m_wr;
      e_ir = rst && (m_owner == 1) && mem_resp;
      e_dr = rst && (m_owner == 2) && mem_resp;
      chk("mem_read",  LINE_W'(mem_read),  LINE_W'(e_rd));
      chk("mem_write", LINE_W'(mem_write), LINE_W'(e_wr));
      chk("mem_addr",  LINE_W'(mem_addr),  LINE_W'(m_addr));
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("i_resp",    LINE_W'(i_resp),    LINE_W'(e_ir));
      chk("d_resp",    LINE_W'(d_resp),    LINE_W'(e_dr));
      chk("i_rdata",   i_rdata, e_ir ? mem_rdata : '0);
      chk("d_rdata",   d_rdata, e_dr ? mem_rdata : '0);
      if (i_resp === 1'b1) begin i_resp_cnt++; resp_log.push_back(1); last_i_rdata = i_rdata; end
      if (d_resp === 1'b1) begin d_resp_cnt++; resp_log.push_back(2); last_d_rdata = d_rdata; end
    end
  end

  // Waits (bounded) for a strobe, then answers after lat strobe cycles; returns in the DONE cycle
  task automatic mem_respond(input int lat, input logic [LINE_W-1:0] data);
    int waited = 0;
    while (!(mem_read || mem_write) && waited < 50) begin
      tick(1);
      waited++;
    end
    if (waited >= 50) chk_i("strobe_timeout", waited, 0);
    repeat (lat - 1) tick(1);
    mem_rdata = data;
    mem_resp  = 1'b1;
    tick(1);
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f;
    int n_i, n_d, d_grants, i_got;
    pat_a = {8{32'hA5A5_0001}};
    pat_b = {8{32'h1234_5678}};
    pat_c = {4{64'hDEAD_BEEF_0BAD_F00D}};
    pat_d = {16{16'hC0DE}};
    pat_e = {32{8'h3C}};
    pat_f = {2{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}};

    rst = 1'b0; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    tick(3);
    chk("rst_mem_read",  LINE_W'(mem_read),  '0);
    chk("rst_mem_write", LINE_W'(mem_write), '0);
    chk("rst_mem_addr",  LINE_W'(mem_addr),  '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_resps",     LINE_W'({i_resp, d_resp}), '0);
    chk("rst_rdata",     i_rdata | d_rdata, '0);
    rst = 1'b1;
    tick(1);

    // I read alone, 5-cycle memory latency
    i_read = 1'b1; i_addr = 32'h60;
    #1 chk("t1_no_strobe_before_grant", LINE_W'(mem_read), '0);
    tick(1);
    chk("t1_mem_read", LINE_W'(mem_read), LINE_W'(1));
    chk("t1_mem_addr", LINE_W'(mem_addr), LINE_W'(32'h60));
    mem_respond(5, pat_a);
    i_read = 1'b0;
    chk_i("t1_i_resp_cnt", i_resp_cnt, 1);
    chk_i("t1_d_resp_cnt", d_resp_cnt, 0);
    chk("t1_i_rdata", last_i_rdata, pat_a);

    // D writeback
    tick(2);
    d_write = 1'b1; d_addr = 32'h1000; d_wdata = pat_b;
    tick(1);
    chk("t2_mem_write", LINE_W'({mem_read, mem_write}), LINE_W'(2'b01));
    chk("t2_mem_wdata", mem_wdata, pat_b);
    chk("t2_mem_addr",  LINE_W'(mem_addr), LINE_W'(32'h1000));
    mem_respond(3, pat_c);
    d_write = 1'b0;
    chk_i("t2_d_resp_cnt", d_resp_cnt, 1);
    chk_i("t2_i_resp_cnt", i_resp_cnt, 1);

    // Simultaneous I and D: D first, then I
    tick(2);
    i_read = 1'b1; i_addr = 32'h80; d_read = 1'b1; d_addr = 32'h2000;
    tick(1);
    chk("t3_d_first_addr", LINE_W'(mem_addr), LINE_W'(32'h2000));
    mem_respond(2, pat_d);
    d_read = 1'b0;
    mem_respond(2, pat_e);
    i_read = 1'b0;
    chk_i("t3_order_first",  resp_log[resp_log.size()-2], 2);
    chk_i("t3_order_second", resp_log[resp_log.size()-1], 1);
    chk("t3_d_rdata", last_d_rdata, pat_d);
    chk("t3_i_rdata", last_i_rdata, pat_e);

    // Reset during D_BUSY abandons the transaction
    tick(2);
    n_d = d_resp_cnt;
    d_read = 1'b1; d_addr = 32'h3000;
    tick(1);
    chk("t4_busy", LINE_W'(mem_read), LINE_W'(1));
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("t4_strobes_after_rst", LINE_W'({mem_read, mem_write}), '0);
    rst = 1'b1; d_read = 1'b0;
    tick(1);
    d_read = 1'b1; d_addr = 32'h3040;
    tick(1);
    chk("t4_regrant_addr", LINE_W'(mem_addr), LINE_W'(32'h3040));
    mem_respond(1, pat_f);
    d_read = 1'b0;
    chk_i("t4_d_resp_cnt", d_resp_cnt, n_d + 1);
    chk("t4_d_rdata", last_d_rdata, pat_f);

    // Stray mem_resp in IDLE and in DONE
    tick(2);
    n_i = i_resp_cnt; n_d = d_resp_cnt;
    mem_rdata = pat_a; mem_resp = 1'b1;
    tick(1);
    mem_resp = 1'b0; mem_rdata = '0;
    tick(1);
    chk("t6_idle_no_strobe", LINE_W'({mem_read, mem_write}), '0);
    i_read = 1'b1; i_addr = 32'hC0;
    tick(1);
    mem_respond(2, pat_b);
    i_read = 1'b0;
    mem_resp = 1'b1;
    tick(1);
    mem_resp = 1'b0;
    tick(1);
    chk_i("t6_i_resp_cnt", i_resp_cnt, n_i + 1);
    chk_i("t6_d_resp_cnt", d_resp_cnt, n_d);
    i_read = 1'b1; i_addr = 32'hE0;
    tick(1);
    chk("t6_normal_after", LINE_W'({mem_read, mem_addr}), LINE_W'({1'b1, 32'hE0}));
    mem_respond(1, pat_c);
    i_read = 1'b0;
    chk_i("t6_i_resp_cnt2", i_resp_cnt, n_i + 2);

    // Continuous D traffic with I waiting
    tick(2);
    d_grants = 0; i_got = 0;
    i_read = 1'b1; i_addr = 32'h100; d_read = 1'b1;
    for (int k = 0; k < 6 && i_got == 0; k++) begin
      d_addr = 32'h4000 + 32'(k * 64);
      mem_respond(1, pat_d);
      if (resp_log[resp_log.size()-1] == 1) i_got = 1;
      else d_grants++;
    end
    d_read = 1'b0;
    if (i_got == 0) mem_respond(1, pat_e);
    i_read = 1'b0;
    chk_i("t5_d_grants", d_grants, STARVE_EN ? 4 : 6);
    chk_i("t5_i_granted", i_got, STARVE_EN ? 1 : 0);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
